// File: rtl/md_unit.sv
// MIPS multiply/divide unit: owns HI/LO, runs MULT/DIV-class ops over a fixed busy window.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MD_MADD_EN is defined.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MD_MADD_EN
   logic [63:0] acc_q, acc_d;
`endif

   logic        st_mul, st_div;
   logic [63:0] prod_s, prod_u;
   logic        sdiv, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
   logic [63:0] res;
   logic        res_we;

   always_comb begin
      st_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_MADD_EN
      st_mul = st_mul || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
               (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
      st_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
   end

   // Datapath works only on the latched operands, so A/B may change freely during RUN.
   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide via magnitudes; 0x80000000 negates to itself, which yields the no-trap result.
   assign sdiv  = (op_q == OP_DIV);
   assign a_neg = sdiv & a_q[31];
   assign b_neg = sdiv & b_q[31];
   assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
   assign b_div = (b_q == 32'd0) ? 32'd1 : b_mag;
   assign q_mag = a_mag / b_div;
   assign r_mag = a_mag % b_div;
   assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

   always_comb begin
      res    = {hi_q, lo_q};
      res_we = 1'b0;
      case (op_q)
         OP_MULT:  begin res = prod_s;     res_we = 1'b1; end
         OP_MULTU: begin res = prod_u;     res_we = 1'b1; end
         OP_DIV, OP_DIVU: begin
            res    = {rem, quo};
            res_we = (b_q != 32'd0);
         end
`ifdef MD_MADD_EN
         OP_MADD:  begin res = acc_q + prod_s; res_we = 1'b1; end
         OP_MADDU: begin res = acc_q + prod_u; res_we = 1'b1; end
         OP_MSUB:  begin res = acc_q - prod_s; res_we = 1'b1; end
         OP_MSUBU: begin res = acc_q - prod_u; res_we = 1'b1; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MD_MADD_EN
      acc_d   = acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (st_mul || st_div) begin
                  op_d    = md_op;
                  a_d     = A;
                  b_d     = B;
`ifdef MD_MADD_EN
                  acc_d   = {hi_q, lo_q};
`endif
                  cnt_d   = st_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                  state_d = S_RUN;
               end else if (md_op == OP_MTHI) begin
                  hi_d = A;
               end else if (md_op == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         S_RUN: begin
            // Starts are ignored here; the controller stalls on busy instead of queueing.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
               if (res_we) begin
                  hi_d = res[63:32];
                  lo_d = res[31:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
`ifdef MD_MADD_EN
         acc_q   <= 64'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MD_MADD_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign busy     = (state_q == S_RUN);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign md_rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops checked against an arithmetic HI/LO model.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, start, rd_hi;
   logic [3:0]  md_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] hi, lo, md_rdata;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
      .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one accepted op on HI/LO, plus its busy length.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l, output int lat);
      longint sa, sb;
      longint unsigned ua, ub, p, acc;
      int si, sj, q, r;
      bit madd;
      sa = longint'(int'(a)); sb = longint'(int'(b));
      ua = longint'(a);       ub = longint'(b);
      acc = {h, l};
      lat = 0;
`ifdef MD_MADD_EN
      madd = 1'b1;
`else
      madd = 1'b0;
`endif
      case (op)
         4'd1: begin p = longint'(sa * sb); {h, l} = p; lat = MC; end
         4'd2: begin p = ua * ub;           {h, l} = p; lat = MC; end
         4'd3: begin
            lat = DC;
            si = int'(a); sj = int'(b);
            if (sj == 0) ;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = 0; end
            else begin q = si / sj; r = si % sj; l = q; h = r; end
         end
         4'd4: begin lat = DC; if (b != 0) begin l = a / b; h = a % b; end end
         4'd5: h = a;
         4'd6: l = a;
         4'd7, 4'd8, 4'd9, 4'd10: if (madd) begin
            lat = MC;
            p = (op == 4'd7 || op == 4'd9) ? longint'(sa * sb) : ua * ub;
            {h, l} = (op <= 4'd8) ? acc + p : acc - p;
         end
         default: ;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el, ph, pl;
      int lat, n;
      ph = m_hi; pl = m_lo; eh = m_hi; el = m_lo;
      model(op, a, b, eh, el, lat);
      @(negedge clk); start = 1'b1; md_op = op; A = a; B = b;
      @(negedge clk); start = 1'b0; A = $urandom; B = $urandom;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         if (n == 0) begin chk("run_hi_hold", hi, ph); chk("run_lo_hold", lo, pl); end
         n++;
         @(negedge clk);
      end
      chk($sformatf("latency_op%0d", op), 32'(n), 32'(lat));
      chk($sformatf("hi_op%0d", op), hi, eh);
      chk($sformatf("lo_op%0d", op), lo, el);
      rd_hi = 1'($urandom);
      #1 chk("md_rdata", md_rdata, rd_hi ? eh : el);
      m_hi = eh; m_lo = el;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      int n;
      reset = 1'b1; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0; rd_hi = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_rdata", md_rdata, 32'd0);
      @(negedge clk); reset = 1'b0;

      // Divide by zero keeps HI/LO; most-negative / -1 does not trap.
      run_op(4'd5, 32'h1234_5678, 32'd0);
      run_op(4'd3, 32'h0000_0009, 32'd0);
      chk("div0_hi", hi, 32'h1234_5678);
      chk("div0_lo", lo, 32'd0);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'd0);

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);
      run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
      chk("multu_hi", hi, 32'h0000_0002);
      chk("multu_lo", lo, 32'hFFFF_FFFA);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_op(4'd4, 32'd7, 32'd2);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);

      // MTLO issued on busy cycle 2 must be dropped.
      @(negedge clk); start = 1'b1; md_op = 4'd1; A = 32'h0000_1234; B = 32'h10;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; md_op = 4'd6; A = 32'h0000_DEAD;
      @(negedge clk); start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      chk("ign_lo_hold", lo, m_lo);
      n = 2;
      while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
      chk("ign_latency", 32'(n), 32'(MC));
      chk("ign_lo", lo, 32'h0001_2340);
      chk("ign_hi", hi, 32'd0);
      rd_hi = 1'b1; #1 chk("rdata_hi", md_rdata, 32'd0);
      rd_hi = 1'b0; #1 chk("rdata_lo", md_rdata, 32'h0001_2340);
      m_hi = 32'd0; m_lo = 32'h0001_2340;

      // Accumulate ops, or NOP when the feature is not built.
      run_op(4'd5, 32'd0, 32'd0);
      run_op(4'd6, 32'hFFFF_FFFF, 32'd0);
      run_op(4'd8, 32'd1, 32'd1);
`ifdef MD_MADD_EN
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
`else
      chk("maddu_nop_hi", hi, 32'd0);
      chk("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

      // Async reset between edges aborts an in-flight divide.
      run_op(4'd5, 32'h0000_0055, 32'd0);
      @(negedge clk); start = 1'b1; md_op = 4'd4; A = 32'd100; B = 32'd7;
      @(negedge clk); start = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk); reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (DC + 3) @(negedge clk);
      chk("arst_nocommit_busy", 32'(busy), 32'd0);
      chk("arst_nocommit_hi", hi, 32'd0);
      chk("arst_nocommit_lo", lo, 32'd0);
      run_op(4'd1, 32'd3, 32'd4);
      chk("post_rst_lo", lo, 32'd12);
      chk("post_rst_hi", hi, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         run_op(rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
